// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Bundles the two writeback request channels, the stall input, the
//            register-file write port and the debug outputs of the write
//            arbiter.
// Ports    : hold                            - pipeline stall
//            req0_valid/ready/addr/data      - ALU writeback channel
//            req1_valid/ready/addr/data      - load writeback channel
//            RegWrite/WriteRegister/WriteData- register-file write port
//            last_grant, drop_count          - round-robin pointer, drop count
// Modports : master - requester / environment side
//            slave  - arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              hold;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    logic              last_grant;
    logic [CNT_W-1:0]  drop_count;

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  RegWrite, WriteRegister, WriteData,
        input  last_grant, drop_count
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output RegWrite, WriteRegister, WriteData,
        output last_grant, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            between the ALU writeback (requester 0) and the load writeback
//            (requester 1). The accepted write is registered and presented on
//            the write port one cycle after acceptance. Writes aimed at the
//            hardwired-zero register are accepted, discarded and counted.
// Ports    : clk   - system clock, all state updates on the rising edge
//            reset - synchronous, active-high reset
//            bus   - slave side of regfile_write_arbiter_if (request channels,
//                    hold, write port, last_grant, drop_count)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    // ------------------------------------------------------------------
    // Grant: a lone valid requester wins; under contention the requester
    // that did not win last time wins, giving strict alternation.
    // ------------------------------------------------------------------
    logic              last_grant_q, last_grant_d;
    logic              regwrite_q,   regwrite_d;
    logic [ADDR_W-1:0] waddr_q,      waddr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [CNT_W-1:0]  drop_q,       drop_d;

    logic              allow;
    logic              grant0;
    logic              grant1;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_is_zero;

    assign allow  = ~reset & ~bus.hold;
    assign grant0 = allow & bus.req0_valid & (~bus.req1_valid |  last_grant_q);
    assign grant1 = allow & bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Grants already include valid, so either grant means a transfer.
    assign xfer        = grant0 | grant1;
    assign win_addr    = grant1 ? bus.req1_addr : bus.req0_addr;
    assign win_data    = grant1 ? bus.req1_data : bus.req0_data;
    assign win_is_zero = (win_addr == c_zero_addr);

    // ------------------------------------------------------------------
    // Next-state for the output stage, pointer and drop counter.
    // ------------------------------------------------------------------
    always_comb begin
        regwrite_d   = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        if (xfer) begin
            last_grant_d = grant1;
            if (win_is_zero) begin
                // Saturate instead of wrapping so a stuck-high count is visible.
                if (drop_q != {CNT_W{1'b1}}) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end else begin
                regwrite_d = 1'b1;
                waddr_d    = win_addr;
                wdata_d    = win_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b1;
            drop_q       <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
        end
    end

    // A write already staged when reset rises must not reach the regfile in
    // the reset cycle itself, so the enable is gated combinationally.
    assign bus.RegWrite      = regwrite_q & ~reset;
    assign bus.WriteRegister = waddr_q;
    assign bus.WriteData     = wdata_q;
    assign bus.last_grant    = last_grant_q;
    assign bus.drop_count    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter. A reference model
//            predicts grants, pointer, drop count and the write-port contents
//            from the arbitration rules; expected writes go into a queue that
//            a separate monitor drains whenever the DUT asserts RegWrite. A
//            behavioural 32-entry regfile is fed from the DUT write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int ZR = 31;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    regfile_write_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file observed through the DUT write port.
    logic [DW-1:0] tb_rf [32];
    initial for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    always @(posedge clk) if (bus.RegWrite === 1'b1) tb_rf[bus.WriteRegister] <= bus.WriteData;

    function automatic logic [DW-1:0] rd(input int a);
        return (a == ZR) ? '0 : tb_rf[a];
    endfunction

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    wr_t           sb_q [$];
    logic [DW-1:0] m_rf [32];
    bit            m_lg    = 1'b1;
    int            m_drop  = 0;
    bit            m_pend  = 1'b0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pdata = '0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            w0 = 0, w1 = 0;
    bit            acc0, acc1;

    initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

    // Accepted-this-cycle flags used by the stimulus to retire requests.
    always @(negedge clk) begin
        acc0 = bus.req0_valid & bus.req0_ready;
        acc1 = bus.req1_valid & bus.req1_ready;
    end

    // Model: checks per-cycle outputs, then advances to the next cycle.
    initial begin
        int expg;
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            expg = -1;
            if (!reset && !bus.hold) begin
                if (bus.req0_valid && bus.req1_valid) expg = m_lg ? 0 : 1;
                else if (bus.req0_valid)              expg = 0;
                else if (bus.req1_valid)              expg = 1;
            end
            chk("req0_ready",    bus.req0_ready,    expg == 0);
            chk("req1_ready",    bus.req1_ready,    expg == 1);
            chk("last_grant",    bus.last_grant,    m_lg);
            chk("drop_count",    bus.drop_count,    m_drop);
            chk("RegWrite",      bus.RegWrite,      m_pend && !reset);
            chk("WriteRegister", bus.WriteRegister, m_waddr);
            chk("WriteData",     bus.WriteData,     m_wdata);

            if (bus.req0_valid && !bus.req0_ready && !reset && !bus.hold) w0++; else w0 = 0;
            if (bus.req1_valid && !bus.req1_ready && !reset && !bus.hold) w1++; else w1 = 0;
            chk("wait0_over_1", w0 > 1, 0);
            chk("wait1_over_1", w1 > 1, 0);

            if (m_pend && !reset) m_rf[m_paddr] = m_pdata;
            m_pend = 1'b0;

            if (reset) begin
                m_lg = 1'b1; m_drop = 0; m_waddr = '0; m_wdata = '0;
                sb_q.delete();
            end else if (expg >= 0) begin
                e.addr = (expg == 0) ? bus.req0_addr : bus.req1_addr;
                e.data = (expg == 0) ? bus.req0_data : bus.req1_data;
                m_lg = (expg == 1);
                if (e.addr == AW'(ZR)) begin
                    if (m_drop < CMAX) m_drop++;
                end else begin
                    m_pend = 1'b1; m_paddr = e.addr; m_pdata = e.data;
                    m_waddr = e.addr; m_wdata = e.data;
                    sb_q.push_back(e);
                end
            end
        end
    end

    // Monitor: every DUT write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.RegWrite === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got write reg %0d data %0h expected no write at %0t",
                             bus.WriteRegister, bus.WriteData, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_addr", bus.WriteRegister, e.addr);
                    chk("sb_data", bus.WriteData,     e.data);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int a, input logic [DW-1:0] d);
        bit done = 0;
        if (r == 0) begin bus.req0_valid = 1; bus.req0_addr = AW'(a); bus.req0_data = d; end
        else        begin bus.req1_valid = 1; bus.req1_addr = AW'(a); bus.req1_data = d; end
        for (int c = 0; c < 20 && !done; c++) begin
            cyc();
            done = (r == 0) ? acc0 : acc1;
        end
        chk("send_accepted", done, 1);
        if (r == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    endtask

    // Both requesters keep valid high continuously with n writes each.
    task automatic contend(input int n, input int a0, input int a1, input int step);
        int k0 = 0, k1 = 0;
        bus.req0_valid = 1; bus.req0_addr = AW'(a0); bus.req0_data = 64'(a0) + 64'h100;
        bus.req1_valid = 1; bus.req1_addr = AW'(a1); bus.req1_data = 64'(a1) + 64'h200;
        for (int c = 0; c < 4 * n + 4 && (k0 < n || k1 < n); c++) begin
            cyc();
            if (acc0) begin
                k0++;
                if (k0 < n) begin
                    bus.req0_addr = AW'(a0 + step * k0); bus.req0_data = 64'(a0 + step * k0) + 64'h100;
                end else bus.req0_valid = 0;
            end
            if (acc1) begin
                k1++;
                if (k1 < n) begin
                    bus.req1_addr = AW'(a1 + step * k1); bus.req1_data = 64'(a1 + step * k1) + 64'h200;
                end else bus.req1_valid = 0;
            end
        end
        chk("contend_done", (k0 >= n) && (k1 >= n), 1);
    endtask

    initial begin
        reset = 1;
        bus.hold = 0;
        bus.req0_valid = 1; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1; bus.req1_addr = '0; bus.req1_data = '0;
        cyc(); cyc();
        reset = 0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        cyc();

        // Single write, visible in the regfile two cycles after acceptance.
        send(0, 5, 64'hDEAD_BEEF);
        cyc(); cyc();
        chk("rf5", rd(5), 64'hDEAD_BEEF);

        // Continuous contention: addresses 1..4.
        contend(2, 1, 2, 2);
        cyc(); cyc();

        // Zero-register writes are dropped and counted, then saturate.
        send(1, ZR, 64'hFFFF);
        cyc(); cyc();
        chk("drop_one", bus.drop_count, 1);
        chk("rf31", rd(ZR), 0);
        for (int i = 0; i < CMAX + 3; i++) send(i % 2, ZR, 64'($urandom));
        cyc();
        chk("drop_sat", bus.drop_count, CMAX);

        // Hold blocks the grant for three cycles.
        bus.hold = 1;
        bus.req0_valid = 1; bus.req0_addr = 9; bus.req0_data = 64'h99;
        cyc(); cyc(); cyc();
        bus.hold = 0;
        cyc();
        chk("hold_release", acc0, 1);
        bus.req0_valid = 0;
        cyc();

        // Same-address collision with last_grant=1: req0 then req1, req1 wins.
        send(1, 10, 64'hA);
        chk("lg_before_coll", bus.last_grant, 1);
        contend(1, 7, 7, 0);
        bus.req0_data = 64'h1;
        cyc(); cyc();
        chk("rf7", rd(7), m_rf[7]);
        chk("rf7_final", rd(7), 64'(7) + 64'h200);

        // Reset during the cycle a write is on the port suppresses it.
        send(0, 12, 64'h1234);
        reset = 1;
        cyc();
        reset = 0;
        cyc();
        chk("rf12_suppressed", rd(12), 0);
        chk("post_reset_addr", bus.WriteRegister, 0);

        // Randomised traffic with hold and occasional reset.
        for (int c = 0; c < 500; c++) begin
            if (!bus.req0_valid && ($urandom % 2 == 1)) begin
                bus.req0_valid = 1;
                bus.req0_addr  = ($urandom % 8 == 0) ? AW'(ZR) : AW'($urandom);
                bus.req0_data  = {$urandom, $urandom};
            end
            if (!bus.req1_valid && ($urandom % 2 == 1)) begin
                bus.req1_valid = 1;
                bus.req1_addr  = ($urandom % 8 == 0) ? AW'(ZR) : AW'($urandom);
                bus.req1_data  = {$urandom, $urandom};
            end
            bus.hold = ($urandom % 8 == 0);
            reset    = ($urandom % 60 == 0);
            cyc();
            if (acc0) bus.req0_valid = 0;
            if (acc1) bus.req1_valid = 0;
        end
        reset = 0; bus.hold = 0;
        for (int c = 0; c < 20 && (bus.req0_valid || bus.req1_valid); c++) begin
            cyc();
            if (acc0) bus.req0_valid = 0;
            if (acc1) bus.req1_valid = 0;
        end
        chk("drain_done", bus.req0_valid | bus.req1_valid, 0);
        cyc(); cyc(); cyc();

        for (int i = 0; i < 32; i++) chk($sformatf("rf_final[%0d]", i), rd(i), m_rf[i]);
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
